// File: rtl/register_dump_reader.sv
// register_dump_reader: walks the register file through one read port
// and streams each index/contents pair out over a valid/ready handshake.
module register_dump_reader #(
    parameter int FIRST_REGISTER = 0,
    parameter int LAST_REGISTER  = 31,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    output logic [4:0]            read_register,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [4:0]            dump_index,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  busy,
    output logic                  done,
    output logic [5:0]            dump_count
);

    localparam logic [4:0] FIRST_IDX = 5'(FIRST_REGISTER);
    localparam logic [4:0] LAST_IDX  = 5'(LAST_REGISTER);
    localparam bit         EMPTY     = FIRST_REGISTER > LAST_REGISTER;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CAPTURE,
        S_SEND,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [4:0]            index_q, index_d;
    logic [4:0]            didx_q, didx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [5:0]            count_q, count_d;

    logic launch;
    logic accept;
    logic last_beat;

    assign launch    = (state_q == S_IDLE) && start && !abort;
    // A beat offered on the same edge as abort is dropped, not counted.
    assign accept    = (state_q == S_SEND) && dump_ready && !abort;
    assign last_beat = (index_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (launch) begin
                    state_d = EMPTY ? S_DONE : S_ADDR;
                end
            end
            S_ADDR: begin
                state_d = abort ? S_IDLE : S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d = abort ? S_IDLE : S_SEND;
            end
            S_SEND: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (dump_ready) begin
                    state_d = last_beat ? S_DONE : S_ADDR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        index_d = index_q;
        didx_d  = didx_q;
        data_d  = data_q;
        count_d = count_q;
        if (launch) begin
            index_d = FIRST_IDX;
            count_d = '0;
        end
        // Address was set up for a full cycle in ADDR before this sample.
        if (state_q == S_CAPTURE && !abort) begin
            data_d = read_data;
            didx_d = index_q;
        end
        if (accept) begin
            count_d = count_q + 6'd1;
            if (!last_beat) begin
                index_d = index_q + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            index_q <= '0;
            didx_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            index_q <= index_d;
            didx_q  <= didx_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        read_register = index_q;
        dump_index    = didx_q;
        dump_data     = data_q;
        dump_count    = count_q;
        dump_valid    = (state_q == S_SEND);
        busy          = (state_q != S_IDLE);
        done          = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_register_dump_reader.sv
// tb_register_dump_reader: drives three parameterisations of the reader
// against a register-file model and an expected-beat queue.
module tb_register_dump_reader;

    logic clk = 1'b0;
    logic reset_n;
    logic start;
    logic abort;
    logic dump_ready;
    int   sel;

    logic [31:0] rf [32];

    logic        start_a, start_b, start_c;
    logic [4:0]  rr_a, rr_b, rr_c;
    logic [31:0] rd_a, rd_b, rd_c;
    logic        v_a, v_b, v_c;
    logic [4:0]  idx_a, idx_b, idx_c;
    logic [31:0] dat_a, dat_b, dat_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic [5:0]  cnt_a, cnt_b, cnt_c;

    logic        o_valid, o_busy, o_done;
    logic [4:0]  o_rreg, o_idx;
    logic [31:0] o_dat;
    logic [5:0]  o_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);

    // Register file: combinational read, register 0 hard-wired to zero.
    assign rd_a = (rr_a == 5'd0) ? 32'd0 : rf[rr_a];
    assign rd_b = (rr_b == 5'd0) ? 32'd0 : rf[rr_b];
    assign rd_c = (rr_c == 5'd0) ? 32'd0 : rf[rr_c];

    register_dump_reader dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .abort(abort),
        .read_register(rr_a), .read_data(rd_a), .dump_valid(v_a),
        .dump_ready(dump_ready), .dump_index(idx_a), .dump_data(dat_a),
        .busy(busy_a), .done(done_a), .dump_count(cnt_a)
    );

    register_dump_reader #(.FIRST_REGISTER(5), .LAST_REGISTER(5)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort),
        .read_register(rr_b), .read_data(rd_b), .dump_valid(v_b),
        .dump_ready(dump_ready), .dump_index(idx_b), .dump_data(dat_b),
        .busy(busy_b), .done(done_b), .dump_count(cnt_b)
    );

    register_dump_reader #(.FIRST_REGISTER(6), .LAST_REGISTER(5)) dut_c (
        .clk(clk), .reset_n(reset_n), .start(start_c), .abort(abort),
        .read_register(rr_c), .read_data(rd_c), .dump_valid(v_c),
        .dump_ready(dump_ready), .dump_index(idx_c), .dump_data(dat_c),
        .busy(busy_c), .done(done_c), .dump_count(cnt_c)
    );

    always_comb begin
        o_valid = v_a;  o_busy = busy_a; o_done = done_a;
        o_rreg  = rr_a; o_idx  = idx_a;  o_dat  = dat_a; o_count = cnt_a;
        if (sel == 1) begin
            o_valid = v_b;  o_busy = busy_b; o_done = done_b;
            o_rreg  = rr_b; o_idx  = idx_b;  o_dat  = dat_b; o_count = cnt_b;
        end else if (sel == 2) begin
            o_valid = v_c;  o_busy = busy_c; o_done = done_c;
            o_rreg  = rr_c; o_idx  = idx_c;  o_dat  = dat_c; o_count = cnt_c;
        end
    end

    function automatic int first_of(input int s);
        return (s == 0) ? 0 : (s == 1) ? 5 : 6;
    endfunction

    function automatic int last_of(input int s);
        return (s == 0) ? 31 : 5;
    endfunction

    function automatic logic [31:0] ref_data(input int k);
        return (k == 0) ? 32'd0 : rf[k];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random();
        rf[0] = 32'd0;
        for (int k = 1; k < 32; k++) rf[k] = $urandom;
    endtask

    // mode 0: ready always high; 1: random ready plus random start
    // while busy; 2: ready withheld five cycles on index 3.
    task automatic run_dump(input int mode, input int limit);
        int          q[$];
        int          first, last, nbeats, cyc, exp_cnt, first_v, done_at;
        int          stall;
        bit          held;
        logic [4:0]  h_idx;
        logic [31:0] h_dat;
        first = first_of(sel);
        last  = last_of(sel);
        for (int k = first; k <= last; k++) q.push_back(k);
        nbeats  = q.size();
        exp_cnt = 0;
        first_v = -1;
        done_at = -1;
        stall   = 0;
        held    = 1'b0;
        h_idx   = '0;
        h_dat   = '0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 64'(o_busy), 64'(1));
        if (first <= last) check("raddr_first", 64'(o_rreg), 64'(first));
        cyc = 0;
        while (done_at < 0 && cyc < limit) begin
            if (o_done) begin
                done_at = cyc;
            end else begin
                dump_ready = 1'b1;
                if (mode == 1) dump_ready = ($urandom_range(0, 2) != 0);
                if (mode == 2 && o_valid && o_idx == 5'd3 && stall < 5) begin
                    dump_ready = 1'b0;
                    stall++;
                end
                if (o_valid) begin
                    if (first_v < 0) first_v = cyc;
                    if (held) begin
                        check("hold_idx", 64'(o_idx), 64'(h_idx));
                        check("hold_data", 64'(o_dat), 64'(h_dat));
                    end
                    if (q.size() > 0) begin
                        check("beat_idx", 64'(o_idx), 64'(q[0]));
                        check("beat_data", 64'(o_dat), 64'(ref_data(q[0])));
                    end else begin
                        check("extra_beat", 64'(o_valid), 64'(0));
                    end
                end else if (held) begin
                    check("valid_dropped", 64'(o_valid), 64'(1));
                end
                check("count_live", 64'(o_count), 64'(exp_cnt));
                held = 1'b0;
                if (o_valid && dump_ready) begin
                    if (q.size() > 0) void'(q.pop_front());
                    exp_cnt++;
                end else if (o_valid) begin
                    held  = 1'b1;
                    h_idx = o_idx;
                    h_dat = o_dat;
                end
                if (mode == 1) start = ($urandom_range(0, 3) == 0);
                tick();
                cyc++;
            end
        end
        start = 1'b0;
        check("done_seen", 64'(done_at >= 0), 64'(1));
        check("beats_left", 64'(q.size()), 64'(0));
        check("count_final", 64'(o_count), 64'(nbeats));
        if (mode == 0) begin
            if (nbeats > 0) check("first_valid_lat", 64'(first_v), 64'(2));
            check("done_cycle", 64'(done_at), 64'(3 * nbeats));
        end
        if (mode == 2) check("stall_cycles", 64'(stall), 64'(5));
        tick();
        check("done_one_cycle", 64'(o_done), 64'(0));
        check("idle_after_done", 64'(o_busy), 64'(0));
        check("count_kept", 64'(o_count), 64'(nbeats));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rreg"}, 64'(o_rreg), 64'(0));
        check({tag, "_valid"}, 64'(o_valid), 64'(0));
        check({tag, "_idx"}, 64'(o_idx), 64'(0));
        check({tag, "_data"}, 64'(o_dat), 64'(0));
        check({tag, "_busy"}, 64'(o_busy), 64'(0));
        check({tag, "_done"}, 64'(o_done), 64'(0));
        check({tag, "_count"}, 64'(o_count), 64'(0));
    endtask

    initial begin
        int cyc;
        reset_n    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        dump_ready = 1'b0;
        sel        = 0;
        rf[0]      = 32'd0;
        for (int k = 1; k < 32; k++) rf[k] = 32'h1000_0000 + k;
        tick();
        tick();
        check_reset_state("reset");
        reset_n = 1'b1;
        tick();

        run_dump(0, 200);
        check("rreg_hold_idle", 64'(o_rreg), 64'(31));

        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", 64'(o_busy), 64'(0));
        check("start_abort_rreg", 64'(o_rreg), 64'(31));
        check("start_abort_cnt", 64'(o_count), 64'(32));
        tick();
        check("start_abort_busy2", 64'(o_busy), 64'(0));

        fill_random();
        run_dump(2, 300);
        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_dump(1, 2000);
        end

        dump_ready = 1'b1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 0;
        while (!(o_valid && o_idx == 5'd7) && cyc < 100) begin
            tick();
            cyc++;
        end
        check("abort_reach7", 64'(o_valid && o_idx == 5'd7), 64'(1));
        check("abort_cnt_pre", 64'(o_count), 64'(7));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", 64'(o_valid), 64'(0));
        check("abort_busy", 64'(o_busy), 64'(0));
        check("abort_done", 64'(o_done), 64'(0));
        check("abort_cnt", 64'(o_count), 64'(7));
        tick();
        check("abort_done2", 64'(o_done), 64'(0));
        check("abort_cnt2", 64'(o_count), 64'(7));

        fill_random();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 0;
        while (!o_valid && cyc < 10) begin
            tick();
            cyc++;
        end
        check("mid_reset_in_send", 64'(o_valid), 64'(1));
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_reset_state("mid_reset");
        run_dump(0, 200);

        sel = 1;
        run_dump(0, 50);
        check("single_rreg_hold", 64'(o_rreg), 64'(5));
        sel = 2;
        run_dump(0, 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/register_dump_reader.md
Name: register_dump_reader

Overview:
- Sequential reader that walks the register file through one read port and streams each register's index and contents out over a valid/ready handshake.
- Used for debug dumps and end-of-test state checks in the pipelined MIPS core.
- Sits beside the register file and drives one read-address input (read_register_1 or read_register_2, chosen at integration) in place of the decode stage while the core is halted.

Parameters:
- FIRST_REGISTER, 0, first register index dumped (0..31).
- LAST_REGISTER, 31, last register index dumped (0..31).
- DATA_WIDTH, 32, register data width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  synchronous active-low reset; one clock; reset is synchronous and active-low.
- start  input  1  pulse; begins a dump when idle.
- abort  input  1  terminates an active dump.
- read_register  output  5  address driven to the register file read port.
- read_data  input  DATA_WIDTH  data returned by the register file for read_register.
- dump_valid  output  1  dump_index/dump_data valid.
- dump_ready  input  1  consumer accepts the current beat.
- dump_index  output  5  register index of the current beat.
- dump_data  output  DATA_WIDTH  captured register contents.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last beat is accepted.
- dump_count  output  6  beats accepted in the current or last dump.

Behaviour:
- Reset (reset_n=0 at a rising edge) applies from any state:
  - state=IDLE.
  - read_register=0, dump_valid=0, dump_index=0, dump_data=0, busy=0, done=0, dump_count=0.
- States: IDLE, ADDR, CAPTURE, SEND, DONE.
- IDLE:
  - start=1 and abort=0: index<=FIRST_REGISTER, dump_count<=0, go to ADDR.
  - If FIRST_REGISTER>LAST_REGISTER, go directly to DONE with no beats.
- ADDR: read_register=index; go to CAPTURE.
- CAPTURE: dump_data<=read_data, dump_index<=index; go to SEND.
  - read_register is held in CAPTURE, so the read is registered with a single cycle of address setup.
- SEND:
  - dump_valid=1; dump_data and dump_index hold stable until accepted.
  - Accepted when dump_valid && dump_ready at a rising edge; dump_count increments.
  - On acceptance: if index==LAST_REGISTER go to DONE, else index<=index+1 and go to ADDR.
- DONE: done=1 for exactly one cycle, busy=1; go to IDLE.
- Latency:
  - start at edge N: read_register valid after N, dump_valid first high after edge N+2.
  - Each further register costs 3 cycles with dump_ready held high.
  - Full 0..31 dump: 96 cycles + 1 DONE cycle.
- Back-pressure: dump_ready low holds SEND indefinitely; no data change, no count change.
- start while busy: ignored.
- abort=1 in ADDR, CAPTURE, SEND or DONE:
  - Go to IDLE next edge; dump_valid=0; no done pulse.
  - dump_count keeps beats accepted so far.
  - Abort in SEND is the only case where valid drops unaccepted.
  - A beat with dump_ready=1 on the same edge as abort is not counted.
- start and abort together in IDLE: abort wins, stay IDLE.
- Index never wraps: LAST_REGISTER=31 terminates at 31; the 5-bit increment beyond 31 never occurs.
- Register 0 is dumped like any other; the register file returns 0 for it.
- read_register holds its last value in IDLE.

Test Plan:
- Reset mid-dump: start, then reset_n=0 in SEND -> next cycle all outputs at reset values, busy=0, a fresh start works.
- Full dump: preload reg k = 0x1000_0000+k (reg0 reads 0), dump_ready=1, start -> 32 beats with indices 0..31 and data 0, 0x1000_0001..0x1000_001F; done one cycle at edge 97 after start; dump_count=32.
- Back-pressure: dump_ready low for 5 cycles on index 3 -> dump_valid held, dump_index=3 and dump_data stable; count steps 3->4 only on acceptance.
- Abort: abort during SEND of index 7 -> dump_valid=0 next cycle, no done, dump_count=7, busy=0.
- Start while busy and start+abort in IDLE: both ignored -> indices unchanged, busy remains as before.
- Parameters FIRST=5, LAST=5: single beat index 5, then done, dump_count=1. Parameters FIRST=6, LAST=5: done pulses with 0 beats.
